// File: rtl/operand_replicator_pkg.sv
// Shared definitions for the operand replicator: mode encodings and
// helpers that turn a mode into its replication factor R.
package opr_pkg;

  typedef enum logic [1:0] {
    MODE_R1   = 2'b00,
    MODE_R2   = 2'b01,
    MODE_R4   = 2'b10,
    MODE_RALL = 2'b11
  } mode_e;

  // R for a given mode; MODE_RALL broadcasts one lane across the whole word.
  function automatic int unsigned rep_factor(input logic [1:0] mode, input int unsigned lanes);
    case (mode)
      MODE_R1: return 1;
      MODE_R2: return 2;
      MODE_R4: return 4;
      default: return lanes;
    endcase
  endfunction

  function automatic int unsigned beats_minus1(input logic [1:0] mode, input int unsigned lanes);
    return rep_factor(mode, lanes) - 1;
  endfunction

endpackage

// File: rtl/operand_replicator_lane_broadcast_mux.sv
// Combinational beat builder: output lane j of beat k takes source lane
// k*(LANES/R) + j/R. R is always a power of two, so the math is shifts.
module lane_broadcast_mux #(
  parameter  int LANES  = 4,
  parameter  int LANE_W = 8,
  localparam int DATA_W = LANES * LANE_W,
  localparam int BW     = $clog2(LANES)
) (
  input  logic [DATA_W-1:0] word,
  input  logic [BW-1:0]     beat,
  input  logic [BW:0]       rep,
  output logic [DATA_W-1:0] beat_data
);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [BW-1:0] src;

      always_comb begin
        src = '0;
        for (int s = 0; s <= BW; s++) begin
          if (rep == (BW+1)'(1 << s)) begin
            src = BW'((int'(beat) << (BW - s)) + (gi >> s));
          end
        end
      end

      assign beat_data[gi*LANE_W +: LANE_W] = word[int'(src)*LANE_W +: LANE_W];
    end
  endgenerate

endmodule

// File: rtl/operand_replicator.sv
// Splits one operand word into R replicated beats for the PE array, with
// valid/ready on both sides and zero-bubble hand-over between words.
module operand_replicator
  import opr_pkg::*;
#(
  parameter  int LANES  = 4,
  parameter  int LANE_W = 8,
  localparam int DATA_W = LANES * LANE_W,
  localparam int BW     = $clog2(LANES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [BW-1:0]     out_beat,
  output logic              out_last
);

  logic [DATA_W-1:0] word_reg, word_next;
  logic [BW:0]       rep_reg, rep_next;
  logic [BW-1:0]     beat_reg, beat_next;
  logic              valid_reg, valid_next;
  logic              last_reg, last_next;
  logic [DATA_W-1:0] data_reg;
  logic [DATA_W-1:0] mux_data;
  logic              load_data;
  logic              accept;
  logic              out_fire;

  assign in_ready = !valid_reg || (out_ready && last_reg);
  assign accept   = in_valid && in_ready;
  assign out_fire = valid_reg && out_ready;

  // IDLE/EMIT/LAST are carried by valid_reg and last_reg; no separate state.
  always_comb begin
    word_next  = word_reg;
    rep_next   = rep_reg;
    beat_next  = beat_reg;
    valid_next = valid_reg;
    last_next  = last_reg;
    load_data  = 1'b0;
    if (accept) begin
      word_next  = in_data;
      rep_next   = (BW+1)'(rep_factor(mode, LANES));
      beat_next  = '0;
      valid_next = 1'b1;
      last_next  = (beats_minus1(mode, LANES) == 0);
      load_data  = 1'b1;
    end else if (out_fire && !last_reg) begin
      beat_next  = beat_reg + 1'b1;
      last_next  = ({1'b0, beat_next} == rep_reg - 1'b1);
      load_data  = 1'b1;
    end else if (out_fire) begin
      valid_next = 1'b0;
    end
  end

  // The mux looks at the next-cycle word/beat so out_data is a plain register.
  lane_broadcast_mux #(
    .LANES  (LANES),
    .LANE_W (LANE_W)
  ) u_mux (
    .word      (word_next),
    .beat      (beat_next),
    .rep       (rep_next),
    .beat_data (mux_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      word_reg  <= '0;
      rep_reg   <= '0;
      beat_reg  <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      data_reg  <= '0;
    end else begin
      word_reg  <= word_next;
      rep_reg   <= rep_next;
      beat_reg  <= beat_next;
      valid_reg <= valid_next;
      last_reg  <= last_next;
      if (load_data) begin
        data_reg <= mux_data;
      end
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign out_beat  = beat_reg;
  assign out_last  = last_reg;

endmodule

// File: tb/tb_operand_replicator.sv
// Directed plus randomized check of operand_replicator against a queue-based
// model of the expected beat stream.
module tb_operand_replicator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [1:0]  out_beat;
  logic        out_last;

  operand_replicator #(.LANES(4), .LANE_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_beat  (out_beat),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          beat;
    bit          last;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] exp_hold = '0;
  int          checks = 0;
  int          failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int r_of(input logic [1:0] m);
    case (m)
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  task automatic push_word(input logic [31:0] d, input logic [1:0] m);
    int    r;
    int    src;
    beat_t b;
    r = r_of(m);
    for (int k = 0; k < r; k++) begin
      b.data = '0;
      for (int j = 0; j < 4; j++) begin
        src = k * (4 / r) + j / r;
        b.data[j*8 +: 8] = d[src*8 +: 8];
      end
      b.beat = k;
      b.last = (k == r - 1);
      exp_q.push_back(b);
    end
  endtask

  // One clock: drive inputs, compare outputs to the model, advance the model.
  task automatic step(input bit rv, input bit iv, input logic [1:0] m,
                      input logic [31:0] d, input bit ordy, input string tag);
    bit exp_v;
    bit exp_ready;
    @(negedge clk);
    reset = rv; in_valid = iv; mode = m; in_data = d; out_ready = ordy;
    #1;
    exp_v     = (exp_q.size() > 0);
    exp_ready = !exp_v || (ordy && exp_q[0].last);
    if (exp_v) exp_hold = exp_q[0].data;
    check_val({tag, ":valid"}, 32'(out_valid), 32'(exp_v));
    check_val({tag, ":data"}, out_data, exp_hold);
    check_val({tag, ":in_ready"}, 32'(in_ready), 32'(exp_ready));
    if (exp_v) begin
      check_val({tag, ":beat"}, 32'(out_beat), 32'(exp_q[0].beat));
      check_val({tag, ":last"}, 32'(out_last), 32'(exp_q[0].last));
    end
    if (rv) begin
      exp_q.delete();
      exp_hold = '0;
    end else begin
      if (exp_v && ordy) void'(exp_q.pop_front());
      if (iv && exp_ready) begin
        push_word(d, m);
        $display("[%0t] %s word accepted data=%h mode=%0d", $time, tag, d, m);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 2'b00, 32'h0, 1, "idle");
  endtask

  initial begin
    repeat (2) @(posedge clk);

    step(0, 0, 2'b00, 32'h0, 1, "rst");
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_data", out_data, 32'h0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);

    // R=1 passthrough
    step(0, 1, 2'b00, 32'hDDCCBBAA, 1, "m00");
    step(0, 0, 2'b00, 32'h0, 1, "m00");
    check_val("m00_data", out_data, 32'hDDCCBBAA);
    check_val("m00_last", 32'(out_last), 32'd1);
    check_val("m00_beat", 32'(out_beat), 32'd0);
    idle(1);

    // R=2
    step(0, 1, 2'b01, 32'hDDCCBBAA, 1, "m01");
    step(0, 0, 2'b00, 32'h0, 1, "m01");
    check_val("m01_b0", out_data, 32'hBBBBAAAA);
    check_val("m01_b0_in_ready", 32'(in_ready), 32'd0);
    step(0, 0, 2'b00, 32'h0, 1, "m01");
    check_val("m01_b1", out_data, 32'hDDDDCCCC);
    check_val("m01_b1_last", 32'(out_last), 32'd1);
    idle(1);

    // R=4
    step(0, 1, 2'b10, 32'hDDCCBBAA, 1, "m10");
    step(0, 0, 2'b00, 32'h0, 1, "m10");
    check_val("m10_b0", out_data, 32'hAAAAAAAA);
    check_val("m10_b0_last", 32'(out_last), 32'd0);
    step(0, 0, 2'b00, 32'h0, 1, "m10");
    check_val("m10_b1", out_data, 32'hBBBBBBBB);
    step(0, 0, 2'b00, 32'h0, 1, "m10");
    check_val("m10_b2", out_data, 32'hCCCCCCCC);
    check_val("m10_b2_last", 32'(out_last), 32'd0);
    step(0, 0, 2'b00, 32'h0, 1, "m10");
    check_val("m10_b3", out_data, 32'hDDDDDDDD);
    check_val("m10_b3_last", 32'(out_last), 32'd1);
    idle(1);

    // stall at beat 1
    step(0, 1, 2'b10, 32'hDDCCBBAA, 1, "stall");
    step(0, 0, 2'b00, 32'h0, 1, "stall");
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 2'b00, 32'h12345678, 0, "stall");
      check_val("stall_data", out_data, 32'hBBBBBBBB);
      check_val("stall_beat", 32'(out_beat), 32'd1);
      check_val("stall_in_ready", 32'(in_ready), 32'd0);
    end
    step(0, 0, 2'b00, 32'h0, 1, "stall");
    step(0, 0, 2'b00, 32'h0, 1, "stall");
    check_val("stall_resume", out_data, 32'hCCCCCCCC);
    idle(2);

    // back-to-back, accept coincides with last beat
    step(0, 1, 2'b01, 32'h44332211, 1, "b2b");
    step(0, 1, 2'b01, 32'h88776655, 1, "b2b");
    check_val("b2b_w1b0", out_data, 32'h22221111);
    step(0, 1, 2'b01, 32'h88776655, 1, "b2b");
    check_val("b2b_w1b1", out_data, 32'h44443333);
    check_val("b2b_accept_on_last", 32'(in_ready), 32'd1);
    step(0, 0, 2'b00, 32'h0, 1, "b2b");
    check_val("b2b_w2b0", out_data, 32'h66665555);
    check_val("b2b_w2b0_valid", 32'(out_valid), 32'd1);
    step(0, 0, 2'b00, 32'h0, 1, "b2b");
    check_val("b2b_w2b1", out_data, 32'h88887777);
    check_val("b2b_w2b1_last", 32'(out_last), 32'd1);
    idle(1);

    // reset mid-word
    step(0, 1, 2'b10, 32'hDDCCBBAA, 1, "rmid");
    step(0, 0, 2'b00, 32'h0, 1, "rmid");
    step(0, 0, 2'b00, 32'h0, 1, "rmid");
    step(1, 0, 2'b00, 32'h0, 1, "rmid");
    check_val("rmid_b2", out_data, 32'hCCCCCCCC);
    step(0, 1, 2'b11, 32'h0F0E0D0C, 1, "rmid");
    check_val("rmid_valid", 32'(out_valid), 32'd0);
    check_val("rmid_data", out_data, 32'h0);
    step(0, 0, 2'b00, 32'h0, 1, "rmid");
    check_val("rmid_next", out_data, 32'h0C0C0C0C);
    check_val("rmid_next_beat", 32'(out_beat), 32'd0);
    idle(4);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(99) == 0), ($urandom_range(9) < 7), 2'($urandom_range(3)),
           $urandom, ($urandom_range(9) < 7), "rand");
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
